// File: rtl/queen_pkg.sv
// rtl/queen_pkg.sv - shared FSM encoding, default board size and index-width helper for the queen board scanner
package queen_pkg;

    // Scanner control states: waiting for a board, or streaming its rows
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DEFAULT_N = 8;

    // Number of bits needed to index 0..value-1 (value >= 2)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_priority_encoder.sv
// rtl/onehot_priority_encoder.sv - lowest-set-bit encoder with empty and multi-hot flags for one board row
module onehot_priority_encoder
    import queen_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] in,
    output logic [W-1:0] col,
    output logic         zero,
    output logic         multi
);

    // Scan from the top so the lowest set column wins; empty row reports column 0
    always_comb begin
        col = '0;
        for (int c = N - 1; c >= 0; c--) begin
            if (in[c]) begin
                col = W'(c);
            end
        end
    end

    assign zero  = (in == '0);
    // Clearing the lowest set bit leaves something only when two or more bits were set
    assign multi = |(in & (in - N'(1)));

endmodule

// File: rtl/queen_board_scanner.sv
// rtl/queen_board_scanner.sv - accepts an NxN board and streams one (row, col) record per row; QUEEN_CONFLICT_CHECK_EN adds column/diagonal attack checking
module queen_board_scanner
    import queen_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           brd_valid,
    output logic           brd_ready,
    input  logic [N*N-1:0] brd_data,
    output logic           pos_valid,
    input  logic           pos_ready,
    output logic [W-1:0]   pos_row,
    output logic [W-1:0]   pos_col,
    output logic           pos_err,
    output logic           pos_conflict,
    output logic           pos_last,
    output logic           board_ok
);

    state_t         state;
    logic [W-1:0]   row_cnt;
    logic [N*N-1:0] board;
    logic           err_acc;

    logic [N-1:0]   row_bits;
    logic [W-1:0]   enc_col;
    logic           enc_zero;
    logic           enc_multi;
    logic           row_err;
    logic           row_conflict;
    logic           conflict_acc;
    logic           consume;
    logic           at_last_row;

    assign row_bits    = board[int'(row_cnt) * N +: N];
    assign row_err     = enc_zero | enc_multi;
    assign consume     = pos_valid & pos_ready;
    assign at_last_row = (row_cnt == W'(N - 1));

    onehot_priority_encoder #(
        .N(N),
        .W(W)
    ) u_encoder (
        .in   (row_bits),
        .col  (enc_col),
        .zero (enc_zero),
        .multi(enc_multi)
    );

    // Control FSM: IDLE takes a board, SCAN hands out one row per accepted record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            brd_ready <= 1'b1;
            pos_valid <= 1'b0;
            row_cnt   <= '0;
            board     <= '0;
            err_acc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (brd_valid && brd_ready) begin
                        board     <= brd_data;
                        row_cnt   <= '0;
                        err_acc   <= 1'b0;
                        state     <= SCAN;
                        brd_ready <= 1'b0;
                        pos_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (consume) begin
                        err_acc <= err_acc | row_err;
                        if (at_last_row) begin
                            row_cnt   <= '0;
                            state     <= IDLE;
                            brd_ready <= 1'b1;
                            pos_valid <= 1'b0;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    brd_ready <= 1'b1;
                    pos_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef QUEEN_CONFLICT_CHECK_EN
    logic [N-1:0]   col_mask;
    logic [2*N-2:0] diag_mask;
    logic [2*N-2:0] adiag_mask;
    logic [W:0]     diag_idx;
    logic [W:0]     adiag_idx;
    logic           accept;

    assign accept    = (state == IDLE) & brd_valid & brd_ready;
    assign diag_idx  = {1'b0, row_cnt} + {1'b0, enc_col};
    assign adiag_idx = {1'b0, row_cnt} + (W + 1)'(N - 1) - {1'b0, enc_col};
    // An empty row places no queen, so it can neither attack nor be attacked
    assign row_conflict = !enc_zero &&
                          (col_mask[enc_col] | diag_mask[diag_idx] | adiag_mask[adiag_idx]);

    // Occupancy masks of earlier rows; only the reported (lowest) column is recorded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_mask     <= '0;
            diag_mask    <= '0;
            adiag_mask   <= '0;
            conflict_acc <= 1'b0;
        end else if (accept) begin
            col_mask     <= '0;
            diag_mask    <= '0;
            adiag_mask   <= '0;
            conflict_acc <= 1'b0;
        end else if (consume) begin
            conflict_acc <= conflict_acc | row_conflict;
            if (!enc_zero) begin
                col_mask[enc_col]     <= 1'b1;
                diag_mask[diag_idx]   <= 1'b1;
                adiag_mask[adiag_idx] <= 1'b1;
            end
        end
    end
`else
    assign row_conflict = 1'b0;
    assign conflict_acc = 1'b0;
`endif

    // Record outputs follow the selected row and read as zero whenever no record is offered
    always_comb begin
        pos_row      = '0;
        pos_col      = '0;
        pos_err      = 1'b0;
        pos_conflict = 1'b0;
        pos_last     = 1'b0;
        board_ok     = 1'b0;
        if (pos_valid) begin
            pos_row      = row_cnt;
            pos_col      = enc_col;
            pos_err      = row_err;
            pos_conflict = row_conflict;
            pos_last     = at_last_row;
            board_ok     = at_last_row && !(err_acc | row_err | conflict_acc | row_conflict);
        end
    end

endmodule

// File: tb/tb_queen_board_scanner.sv
// tb/tb_queen_board_scanner.sv - randomized self-checking bench for queen_board_scanner against a board-level reference model
module tb_queen_board_scanner;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int NN = N * N;
`ifdef QUEEN_CONFLICT_CHECK_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] row;
        logic [W-1:0] col;
        logic         err;
        logic         conf;
        logic         last;
        logic         ok;
    } rec_t;

    logic          clk;
    logic          rst_n;
    logic          brd_valid;
    logic          brd_ready;
    logic [NN-1:0] brd_data;
    logic          pos_valid;
    logic          pos_ready;
    logic [W-1:0]  pos_row;
    logic [W-1:0]  pos_col;
    logic          pos_err;
    logic          pos_conflict;
    logic          pos_last;
    logic          board_ok;

    rec_t exp_rec[N];
    rec_t obs[$];
    int   n_checks;
    int   n_pass;

    queen_board_scanner #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .brd_valid   (brd_valid),
        .brd_ready   (brd_ready),
        .brd_data    (brd_data),
        .pos_valid   (pos_valid),
        .pos_ready   (pos_ready),
        .pos_row     (pos_row),
        .pos_col     (pos_col),
        .pos_err     (pos_err),
        .pos_conflict(pos_conflict),
        .pos_last    (pos_last),
        .board_ok    (board_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t cur_rec();
        rec_t r;
        r.row  = pos_row;
        r.col  = pos_col;
        r.err  = pos_err;
        r.conf = pos_conflict;
        r.last = pos_last;
        r.ok   = board_ok;
        return r;
    endfunction

    function automatic logic [NN-1:0] from_cols(input int cols[N]);
        logic [NN-1:0] b;
        b = '0;
        for (int r = 0; r < N; r++) b[r*N + cols[r]] = 1'b1;
        return b;
    endfunction

    function automatic logic [NN-1:0] random_perm_board();
        int p[N];
        int j;
        int t;
        for (int i = 0; i < N; i++) p[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j = int'($urandom_range(i));
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        return from_cols(p);
    endfunction

    // Reference: a row is good when it holds exactly one queen; a queen is attacked when an
    // earlier placed queen shares its column or sits on a diagonal (equal row and column distance)
    task automatic build_expected(input logic [NN-1:0] b);
        int qr[$];
        int qc[$];
        bit bad;
        logic [N-1:0] row;
        int cnt;
        int col;
        bit found;
        bit conf;
        bad = 1'b0;
        for (int r = 0; r < N; r++) begin
            row   = b[r*N +: N];
            cnt   = $countones(row);
            col   = 0;
            found = 1'b0;
            conf  = 1'b0;
            for (int c = 0; c < N; c++) begin
                if (row[c] && !found) begin
                    col   = c;
                    found = 1'b1;
                end
            end
            if (CONF_EN && cnt > 0) begin
                foreach (qr[i]) begin
                    if (qc[i] == col || (r - qr[i]) == (col - qc[i]) || (r - qr[i]) == (qc[i] - col))
                        conf = 1'b1;
                end
            end
            if (cnt > 0) begin
                qr.push_back(r);
                qc.push_back(col);
            end
            bad = bad | (cnt != 1) | conf;
            exp_rec[r] = '{row: W'(r), col: W'(col), err: (cnt != 1), conf: conf,
                           last: (r == N - 1), ok: (r == N - 1) && !bad};
        end
    endtask

    // Offer a board from a negedge; returns at the negedge of the first record cycle
    task automatic send_board(input logic [NN-1:0] b, output bit to);
        int g;
        to = 1'b0;
        g  = 0;
        brd_data  = b;
        brd_valid = 1'b1;
        while (!brd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!brd_ready) begin
            to = 1'b1;
            brd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        brd_valid = 1'b0;
    endtask

    // Stream one board, consuming records with the given ready probability
    task automatic stream_board(input logic [NN-1:0] b, input int pct,
                                output int last_cycle, output bit ready_after, output bit to);
        int cyc;
        bit done;
        obs.delete();
        last_cycle  = 0;
        ready_after = 1'b0;
        send_board(b, to);
        if (to) return;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 500) begin
            cyc++;
            if (pos_valid) begin
                pos_ready = (int'($urandom_range(99)) < pct);
                if (pos_ready) begin
                    obs.push_back(cur_rec());
                    if (pos_last) begin
                        done = 1'b1;
                        last_cycle = cyc;
                    end
                end
            end
            @(negedge clk);
        end
        ready_after = brd_ready;
        pos_ready   = 1'b0;
        to          = !done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; brd_valid = 1'b0; pos_ready = 1'b0; brd_data = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (pos_valid !== 1'b0) $display("FAIL reset_valid_in_reset got %b exp 0", pos_valid); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (brd_ready !== 1'b1) $display("FAIL reset_brd_ready got %b exp 1", brd_ready); else n_pass++;
        n_checks++; if (pos_valid !== 1'b0) $display("FAIL reset_pos_valid got %b exp 0", pos_valid); else n_pass++;
        n_checks++;
        if (cur_rec() !== rec_t'(0)) $display("FAIL reset_pos_fields got %h exp 0", cur_rec()); else n_pass++;
    endtask

    task automatic test_solution();
        int c8[N];
        int lc;
        bit ra;
        bit to;
        logic [NN-1:0] b;
        c8 = '{0, 4, 7, 5, 2, 6, 1, 3};
        b  = from_cols(c8);
        build_expected(b);
        stream_board(b, 100, lc, ra, to);
        n_checks++; if (to !== 1'b0) $display("FAIL sol_timeout got %b exp 0", to); else n_pass++;
        n_checks++; if (obs.size() != N) $display("FAIL sol_count got %0d exp %0d", obs.size(), N); else n_pass++;
        n_checks++; if (lc != N) $display("FAIL sol_last_cycle got %0d exp %0d", lc, N); else n_pass++;
        n_checks++; if (ra !== 1'b1) $display("FAIL sol_ready_after got %b exp 1", ra); else n_pass++;
        for (int k = 0; k < obs.size() && k < N; k++) begin
            n_checks++;
            if (obs[k].col !== W'(c8[k]) || obs[k].err !== 1'b0 || obs[k].conf !== 1'b0)
                $display("FAIL sol_row%0d got col %0d err %b conf %b exp col %0d err 0 conf 0",
                         k, obs[k].col, obs[k].err, obs[k].conf, c8[k]);
            else n_pass++;
            n_checks++; if (obs[k] !== exp_rec[k]) $display("FAIL sol_model_row%0d got %h exp %h", k, obs[k], exp_rec[k]); else n_pass++;
        end
        if (obs.size() == N) begin
            n_checks++;
            if (obs[N-1].last !== 1'b1 || obs[N-1].ok !== 1'b1)
                $display("FAIL sol_last_ok got last %b ok %b exp 1 1", obs[N-1].last, obs[N-1].ok);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        int c8[N];
        int lc;
        bit ra;
        bit to;
        logic [NN-1:0] b;
        c8 = '{0, 4, 7, 5, 2, 6, 1, 3};
        b  = from_cols(c8);
        b[3*N +: N] = 8'b0010_0100;
        b[5*N +: N] = 8'b0000_0000;
        build_expected(b);
        stream_board(b, 100, lc, ra, to);
        n_checks++; if (obs.size() != N) $display("FAIL err_count got %0d exp %0d", obs.size(), N); else n_pass++;
        if (obs.size() == N) begin
            n_checks++;
            if (obs[3].col !== 3'd2 || obs[3].err !== 1'b1) $display("FAIL err_row3 got col %0d err %b exp 2 1", obs[3].col, obs[3].err); else n_pass++;
            n_checks++;
            if (obs[5].col !== 3'd0 || obs[5].err !== 1'b1 || obs[5].conf !== 1'b0)
                $display("FAIL err_row5 got col %0d err %b conf %b exp 0 1 0", obs[5].col, obs[5].err, obs[5].conf);
            else n_pass++;
            n_checks++; if (obs[7].ok !== 1'b0) $display("FAIL err_board_ok got %b exp 0", obs[7].ok); else n_pass++;
            for (int k = 0; k < N; k++) begin
                n_checks++; if (obs[k] !== exp_rec[k]) $display("FAIL err_model_row%0d got %h exp %h", k, obs[k], exp_rec[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NN-1:0] b;
        bit to;
        int g;
        int k;
        rec_t snap;
        b = random_perm_board();
        build_expected(b);
        send_board(b, to);
        n_checks++; if (to !== 1'b0) $display("FAIL bp_accept got timeout %b exp 0", to); else n_pass++;
        pos_ready = 1'b1;
        g = 0;
        while (pos_row != 3'd2 && g < 20) begin
            @(negedge clk);
            g++;
        end
        snap = cur_rec();
        n_checks++; if (snap !== exp_rec[2]) $display("FAIL bp_row2 got %h exp %h", snap, exp_rec[2]); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            pos_ready = (i == 3);
            n_checks++;
            if (cur_rec() !== exp_rec[2] || pos_valid !== 1'b1)
                $display("FAIL bp_hold%0d got %h valid %b exp %h valid 1", i, cur_rec(), pos_valid, exp_rec[2]);
            else n_pass++;
            @(negedge clk);
        end
        pos_ready = 1'b1;
        k = 3;
        g = 0;
        while (k < N && g < 20) begin
            n_checks++; if (cur_rec() !== exp_rec[k]) $display("FAIL bp_row%0d got %h exp %h", k, cur_rec(), exp_rec[k]); else n_pass++;
            k++;
            g++;
            @(negedge clk);
        end
        pos_ready = 1'b0;
        n_checks++; if (brd_ready !== 1'b1 || pos_valid !== 1'b0) $display("FAIL bp_done got ready %b valid %b exp 1 0", brd_ready, pos_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        logic [NN-1:0] b;
        bit to;
        int g;
        int lc;
        bit ra;
        b = random_perm_board();
        b[4*N-1:0] = '0;
        send_board(b, to);
        pos_ready = 1'b1;
        g = 0;
        while (pos_row != 3'd4 && g < 20) begin
            @(negedge clk);
            g++;
        end
        n_checks++; if (pos_row !== 3'd4) $display("FAIL rst_reach_row4 got %0d exp 4", pos_row); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (pos_valid !== 1'b0) $display("FAIL rst_valid_immediate got %b exp 0", pos_valid); else n_pass++;
        n_checks++; if (cur_rec() !== rec_t'(0)) $display("FAIL rst_fields got %h exp 0", cur_rec()); else n_pass++;
        pos_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (brd_ready !== 1'b1 || pos_valid !== 1'b0) $display("FAIL rst_after got ready %b valid %b exp 1 0", brd_ready, pos_valid); else n_pass++;
        b = random_perm_board();
        build_expected(b);
        stream_board(b, 70, lc, ra, to);
        n_checks++; if (obs.size() != N) $display("FAIL rst_next_count got %0d exp %0d", obs.size(), N); else n_pass++;
        for (int k = 0; k < obs.size() && k < N; k++) begin
            n_checks++; if (obs[k] !== exp_rec[k]) $display("FAIL rst_next_row%0d got %h exp %h", k, obs[k], exp_rec[k]); else n_pass++;
        end
    endtask

    task automatic test_conflict();
        int ca[N];
        int cb[N];
        int cc[N];
        int lc;
        bit ra;
        bit to;
        ca = '{0, 2, 4, 6, 1, 3, 5, 7};
        cb = '{0, 1, 2, 3, 4, 5, 6, 7};
        cc = '{3, 3, 3, 3, 3, 3, 3, 3};
        build_expected(from_cols(ca));
        stream_board(from_cols(ca), 100, lc, ra, to);
        if (obs.size() == N) begin
            n_checks++; if (obs[1].conf !== 1'b0 || obs[1].col !== 3'd2) $display("FAIL conf_a_row1 got conf %b col %0d exp 0 2", obs[1].conf, obs[1].col); else n_pass++;
            n_checks++; if (obs[7] !== exp_rec[7]) $display("FAIL conf_a_last got %h exp %h", obs[7], exp_rec[7]); else n_pass++;
        end else begin
            n_checks++; $display("FAIL conf_a_count got %0d exp %0d", obs.size(), N);
        end
        build_expected(from_cols(cb));
        stream_board(from_cols(cb), 100, lc, ra, to);
        if (obs.size() == N) begin
            n_checks++; if (obs[1].conf !== CONF_EN) $display("FAIL conf_diag_row1 got %b exp %b", obs[1].conf, CONF_EN); else n_pass++;
            for (int k = 0; k < N; k++) begin
                n_checks++; if (obs[k] !== exp_rec[k]) $display("FAIL conf_b_row%0d got %h exp %h", k, obs[k], exp_rec[k]); else n_pass++;
            end
        end else begin
            n_checks++; $display("FAIL conf_b_count got %0d exp %0d", obs.size(), N);
        end
        build_expected(from_cols(cc));
        stream_board(from_cols(cc), 100, lc, ra, to);
        if (obs.size() == N) begin
            n_checks++; if (obs[1].conf !== CONF_EN) $display("FAIL conf_col_row1 got %b exp %b", obs[1].conf, CONF_EN); else n_pass++;
            n_checks++; if (obs[7].ok !== !CONF_EN) $display("FAIL conf_col_board_ok got %b exp %b", obs[7].ok, !CONF_EN); else n_pass++;
        end else begin
            n_checks++; $display("FAIL conf_c_count got %0d exp %0d", obs.size(), N);
        end
    endtask

    task automatic test_held_valid();
        logic [NN-1:0] b1;
        logic [NN-1:0] b2;
        rec_t e1[N];
        rec_t e2[N];
        bit to;
        b1 = random_perm_board();
        b2 = random_perm_board();
        b2[N +: N] = 8'b1000_0001;
        build_expected(b1); e1 = exp_rec;
        build_expected(b2); e2 = exp_rec;
        send_board(b1, to);
        brd_data  = b2;
        brd_valid = 1'b1;
        pos_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            n_checks++; if (cur_rec() !== e1[k]) $display("FAIL held_b1_row%0d got %h exp %h", k, cur_rec(), e1[k]); else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (brd_ready !== 1'b1) $display("FAIL held_idle_ready got %b exp 1", brd_ready); else n_pass++;
        @(negedge clk);
        brd_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (cur_rec() !== e2[k] || pos_valid !== 1'b1) $display("FAIL held_b2_row%0d got %h valid %b exp %h", k, cur_rec(), pos_valid, e2[k]);
            else n_pass++;
            @(negedge clk);
        end
        pos_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [NN-1:0] b;
        int kind;
        int pct;
        int lc;
        bit ra;
        bit to;
        for (int t = 0; t < 25; t++) begin
            kind = int'($urandom_range(2));
            if (kind == 0) begin
                b = random_perm_board();
            end else if (kind == 1) begin
                b = '0;
                for (int r = 0; r < N; r++) b[r*N + int'($urandom_range(N - 1))] = 1'b1;
            end else begin
                b = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            end
            pct = int'($urandom_range(100, 30));
            build_expected(b);
            stream_board(b, pct, lc, ra, to);
            n_checks++;
            if (to !== 1'b0 || obs.size() != N || ra !== 1'b1)
                $display("FAIL rand%0d_stream got timeout %b count %0d ready %b exp 0 %0d 1", t, to, obs.size(), ra, N);
            else n_pass++;
            for (int k = 0; k < obs.size() && k < N; k++) begin
                n_checks++; if (obs[k] !== exp_rec[k]) $display("FAIL rand%0d_row%0d got %h exp %h", t, k, obs[k], exp_rec[k]); else n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_solution();
        test_errors();
        test_backpressure();
        test_reset_mid_scan();
        test_conflict();
        test_held_valid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
